pipelined_decoder: RTL

- Registered instruction decoder for the pipelined MIPS core; replaces the single-cycle combinational decoder.
- Decodes one instruction per cycle into an ID/EX control word, with a valid/ready handshake on both sides.
- Detects load-use hazards and stalls on them.
- Contains a multi-cycle MULTU/DIVU busy tracker that interlocks MFHI/MFLO and back-to-back mul/div.
- Sits between the IF/ID register and the execute stage.

---
 rtl/pipelined_decoder.sv | 383 ++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipelined_decoder.sv
// pipelined_decoder
// Registered MIPS instruction decoder sitting between the IF/ID register and
// the execute stage. One instruction per cycle is decoded into an ID/EX
// control word behind a valid/ready handshake. Load-use hazards and HI/LO
// accesses during an in-flight MULTU/DIVU hold the instruction upstream.
// A small FSM tracks the multi-cycle mul/div unit.

module pipelined_decoder #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 32,
   parameter int unsigned CNT_W      = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] instr,
   input  logic            flush,
   input  logic            ex_ready,
   input  logic            ex_load_valid,
   input  logic [4:0]      ex_load_dest,
   output logic            out_valid,
   output logic            memtoreg,
   output logic            memwrite,
   output logic            alusrcbimm,
   output logic            regwrite,
   output logic            dojump,
   output logic            dojr,
   output logic [1:0]      branch_kind,
   output logic [4:0]      destreg,
   output logic [2:0]      alucontrol,
   output logic [1:0]      hilo_op,
   output logic            illegal,
   output logic            md_busy,
   output logic            md_done
);

   // ------------------------------------------------------------------
   // Encodings
   // ------------------------------------------------------------------
   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;

   localparam logic [5:0] FN_JR     = 6'h08;
   localparam logic [5:0] FN_MFHI   = 6'h10;
   localparam logic [5:0] FN_MFLO   = 6'h12;
   localparam logic [5:0] FN_MULTU  = 6'h19;
   localparam logic [5:0] FN_DIVU   = 6'h1B;
   localparam logic [5:0] FN_ADDU   = 6'h21;
   localparam logic [5:0] FN_SUBU   = 6'h23;
   localparam logic [5:0] FN_AND    = 6'h24;
   localparam logic [5:0] FN_OR     = 6'h25;
   localparam logic [5:0] FN_SLTU   = 6'h2B;

   localparam logic [1:0] BK_NONE   = 2'b00;
   localparam logic [1:0] BK_BEQ    = 2'b01;
   localparam logic [1:0] BK_BLTZ   = 2'b10;

   localparam logic [1:0] HL_NONE   = 2'b00;
   localparam logic [1:0] HL_START  = 2'b01;
   localparam logic [1:0] HL_MFHI   = 2'b10;
   localparam logic [1:0] HL_MFLO   = 2'b11;

   // ID/EX control word
   typedef struct packed {
      logic       memtoreg;
      logic       memwrite;
      logic       alusrcbimm;
      logic       regwrite;
      logic       dojump;
      logic       dojr;
      logic [1:0] branch_kind;
      logic [4:0] destreg;
      logic [2:0] alucontrol;
      logic [1:0] hilo_op;
      logic       illegal;
   } ctl_t;

   // Inert control word: no writes, no jumps, ALU code 010. Also the reset value.
   localparam ctl_t CTL_NONE = '{
      memtoreg:    1'b0,
      memwrite:    1'b0,
      alusrcbimm:  1'b0,
      regwrite:    1'b0,
      dojump:      1'b0,
      dojr:        1'b0,
      branch_kind: BK_NONE,
      destreg:     5'd0,
      alucontrol:  3'b010,
      hilo_op:     HL_NONE,
      illegal:     1'b0
   };

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_MUL  = 2'b01,
      MD_DIV  = 2'b10
   } md_state_e;

   // ------------------------------------------------------------------
   // Signals
   // ------------------------------------------------------------------
   logic [5:0] opcode_s;
   logic [5:0] funct_s;
   logic [4:0] rs_s;
   logic [4:0] rt_s;
   logic [4:0] rd_s;
   logic       unused_shamt_s;

   ctl_t       dec_s;
   logic       use_rs_s;
   logic       use_rt_s;
   logic       is_div_s;

   logic       load_hazard_s;
   logic       md_hazard_s;
   logic       in_ready_s;
   logic       capture_s;

   logic       out_valid_q, out_valid_d;
   ctl_t       ctl_q, ctl_d;

   md_state_e  md_state_q, md_state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic       md_done_q, md_done_d;

   // ------------------------------------------------------------------
   // Instruction fields (shamt is never needed by this decoder)
   // ------------------------------------------------------------------
   assign opcode_s       = instr[XLEN-1 -: 6];
   assign rs_s           = instr[25:21];
   assign rt_s           = instr[20:16];
   assign rd_s           = instr[15:11];
   assign funct_s        = instr[5:0];
   assign unused_shamt_s = ^instr[10:6];

   // Decode the presented instruction into a control word and register-use flags.
   always_comb begin
      dec_s    = CTL_NONE;
      use_rs_s = 1'b0;
      use_rt_s = 1'b0;
      is_div_s = 1'b0;
      case (opcode_s)
         OP_RTYPE: begin
            dec_s.destreg  = rd_s;
            dec_s.regwrite = 1'b1;
            case (funct_s)
               FN_ADDU: begin
                  dec_s.alucontrol = 3'b101;
                  use_rs_s         = 1'b1;
                  use_rt_s         = 1'b1;
               end
               FN_SUBU: begin
                  dec_s.alucontrol = 3'b001;
                  use_rs_s         = 1'b1;
                  use_rt_s         = 1'b1;
               end
               FN_AND: begin
                  dec_s.alucontrol = 3'b111;
                  use_rs_s         = 1'b1;
                  use_rt_s         = 1'b1;
               end
               FN_OR: begin
                  dec_s.alucontrol = 3'b110;
                  use_rs_s         = 1'b1;
                  use_rt_s         = 1'b1;
               end
               FN_SLTU: begin
                  dec_s.alucontrol = 3'b000;
                  use_rs_s         = 1'b1;
                  use_rt_s         = 1'b1;
               end
               FN_MULTU: begin
                  dec_s.regwrite   = 1'b0;
                  dec_s.alucontrol = 3'b100;
                  dec_s.hilo_op    = HL_START;
                  use_rs_s         = 1'b1;
                  use_rt_s         = 1'b1;
               end
               FN_DIVU: begin
                  dec_s.regwrite   = 1'b0;
                  dec_s.alucontrol = 3'b100;
                  dec_s.hilo_op    = HL_START;
                  use_rs_s         = 1'b1;
                  use_rt_s         = 1'b1;
                  is_div_s         = 1'b1;
               end
               FN_MFHI: begin
                  dec_s.alucontrol = 3'b101;
                  dec_s.hilo_op    = HL_MFHI;
               end
               FN_MFLO: begin
                  dec_s.alucontrol = 3'b101;
                  dec_s.hilo_op    = HL_MFLO;
               end
               FN_JR: begin
                  dec_s.regwrite   = 1'b0;
                  dec_s.dojump     = 1'b1;
                  dec_s.dojr       = 1'b1;
                  use_rs_s         = 1'b1;
               end
               default: begin
                  dec_s         = CTL_NONE;
                  dec_s.illegal = 1'b1;
               end
            endcase
         end
         OP_LW: begin
            dec_s.alusrcbimm = 1'b1;
            dec_s.memtoreg   = 1'b1;
            dec_s.regwrite   = 1'b1;
            dec_s.destreg    = rt_s;
            dec_s.alucontrol = 3'b101;
            use_rs_s         = 1'b1;
         end
         OP_SW: begin
            dec_s.memwrite   = 1'b1;
            dec_s.alusrcbimm = 1'b1;
            dec_s.alucontrol = 3'b101;
            use_rs_s         = 1'b1;
            use_rt_s         = 1'b1;
         end
         OP_BEQ: begin
            dec_s.branch_kind = BK_BEQ;
            dec_s.alucontrol  = 3'b001;
            use_rs_s          = 1'b1;
            use_rt_s          = 1'b1;
         end
         OP_REGIMM: begin
            dec_s.branch_kind = BK_BLTZ;
            dec_s.alucontrol  = 3'b010;
            use_rs_s          = 1'b1;
         end
         OP_ADDIU: begin
            dec_s.alusrcbimm = 1'b1;
            dec_s.regwrite   = 1'b1;
            dec_s.destreg    = rt_s;
            dec_s.alucontrol = 3'b101;
            use_rs_s         = 1'b1;
         end
         OP_ORI: begin
            dec_s.alusrcbimm = 1'b1;
            dec_s.regwrite   = 1'b1;
            dec_s.destreg    = rt_s;
            dec_s.alucontrol = 3'b110;
            use_rs_s         = 1'b1;
         end
         OP_LUI: begin
            dec_s.alusrcbimm = 1'b1;
            dec_s.regwrite   = 1'b1;
            dec_s.destreg    = rt_s;
            dec_s.alucontrol = 3'b011;
         end
         OP_J: begin
            dec_s.dojump = 1'b1;
         end
         OP_JAL: begin
            dec_s.dojump     = 1'b1;
            dec_s.regwrite   = 1'b1;
            dec_s.destreg    = 5'd31;
            dec_s.alucontrol = 3'b101;
         end
         default: begin
            dec_s.illegal = 1'b1;
         end
      endcase
   end

   // Hazard detection and input handshake; flush always refuses the new instruction.
   always_comb begin
      load_hazard_s = ex_load_valid && (ex_load_dest != 5'd0) &&
                      ((use_rs_s && (ex_load_dest == rs_s)) ||
                       (use_rt_s && (ex_load_dest == rt_s)));
      md_hazard_s   = (md_state_q != MD_IDLE) && (dec_s.hilo_op != HL_NONE);
      in_ready_s    = !flush && !load_hazard_s && !md_hazard_s &&
                      (!out_valid_q || ex_ready);
      capture_s     = in_valid && in_ready_s;
   end

   // Next state of the ID/EX register: flush kills, capture loads, EX consumption drains.
   always_comb begin
      out_valid_d = out_valid_q;
      ctl_d       = ctl_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (capture_s) begin
         out_valid_d = 1'b1;
         ctl_d       = dec_s;
      end else if (ex_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // ID/EX register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         ctl_q       <= CTL_NONE;
      end else begin
         out_valid_q <= out_valid_d;
         ctl_q       <= ctl_d;
      end
   end

   // Mul/div tracker: load the cycle count on a captured MULTU/DIVU, count down to 1, then pulse done.
   always_comb begin
      md_state_d = md_state_q;
      cnt_d      = cnt_q;
      md_done_d  = 1'b0;
      case (md_state_q)
         MD_IDLE: begin
            if (capture_s && (dec_s.hilo_op == HL_START)) begin
               if (is_div_s) begin
                  md_state_d = MD_DIV;
                  cnt_d      = CNT_W'(DIV_CYCLES);
               end else begin
                  md_state_d = MD_MUL;
                  cnt_d      = CNT_W'(MUL_CYCLES);
               end
            end else begin
               md_state_d = MD_IDLE;
            end
         end
         MD_MUL, MD_DIV: begin
            if (cnt_q == CNT_W'(1)) begin
               md_state_d = MD_IDLE;
               cnt_d      = {CNT_W{1'b0}};
               md_done_d  = 1'b1;
            end else begin
               cnt_d      = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            md_state_d = MD_IDLE;
            cnt_d      = {CNT_W{1'b0}};
         end
      endcase
   end

   // Mul/div state, counter and completion pulse; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         md_state_q <= MD_IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         md_done_q  <= 1'b0;
      end else begin
         md_state_q <= md_state_d;
         cnt_q      <= cnt_d;
         md_done_q  <= md_done_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign in_ready    = in_ready_s;
   assign out_valid   = out_valid_q;
   assign memtoreg    = ctl_q.memtoreg;
   assign memwrite    = ctl_q.memwrite;
   assign alusrcbimm  = ctl_q.alusrcbimm;
   assign regwrite    = ctl_q.regwrite;
   assign dojump      = ctl_q.dojump;
   assign dojr        = ctl_q.dojr;
   assign branch_kind = ctl_q.branch_kind;
   assign destreg     = ctl_q.destreg;
   assign alucontrol  = ctl_q.alucontrol;
   assign hilo_op     = ctl_q.hilo_op;
   assign illegal     = ctl_q.illegal;
   assign md_busy     = (md_state_q != MD_IDLE);
   assign md_done     = md_done_q;

endmodule
